// File: rtl/game_pkg.sv
// Shared game-mode encoding and default timing constants for the mouse game.
// Pure declarations: no latency or flow-control behaviour of its own.
package game_pkg;

  // START and GAME keep their original codes so existing consumers are unaffected.
  typedef enum logic [2:0] {
    START     = 3'd0,
    GAME      = 3'd1,
    COUNTDOWN = 3'd2,
    PAUSE     = 3'd3,
    OVER      = 3'd4
  } game_mode;

  localparam int DEF_FPS         = 60;
  localparam int DEF_COUNTDOWN_S = 3;
  localparam int DEF_ROUND_S     = 30;

endpackage

// File: rtl/round_control_if.sv
// Signal bundle between the mouse/video front-end and the round sequencer.
// Pulse-based inputs, registered outputs; no backpressure.
interface round_control_if #(
  parameter int CD_W    = 2,
  parameter int TL_W    = 5,
  parameter int SCORE_W = 10
);
  import game_pkg::*;

  logic               frame_tick;
  logic               mouse_right;
  logic               hit;
  game_mode           mode;
  logic [CD_W-1:0]    countdown;
  logic [TL_W-1:0]    time_left;
  logic [SCORE_W-1:0] score;
  logic               spawn_req;
  logic               round_done;

  modport master (
    output frame_tick, mouse_right, hit,
    input  mode, countdown, time_left, score, spawn_req, round_done
  );

  modport slave (
    input  frame_tick, mouse_right, hit,
    output mode, countdown, time_left, score, spawn_req, round_done
  );

endinterface

// File: rtl/frame_sec_timer.sv
// Divides frame_tick pulses down to a one-per-second pulse, with enable and clear.
// sec_pulse_o is combinational with the final frame_tick of each second; never stalls.
module frame_sec_timer #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sec_pulse_o
);

  localparam int              FC_W = (FRAMES_PER_SEC > 2) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0] LAST = FC_W'(FRAMES_PER_SEC - 1);

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

  assign sec_pulse_o = en_i & frame_tick_i & (frame_cnt_q == LAST);

  // Clear wins over counting so a phase entry always starts a full second.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (clr_i) begin
      frame_cnt_d = '0;
    end else if (en_i && frame_tick_i) begin
      frame_cnt_d = (frame_cnt_q == LAST) ? '0 : frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: rtl/round_control.sv
// Round sequencer: START -> COUNTDOWN -> GAME <-> PAUSE -> OVER, with score and second counters.
// All outputs registered, updating one cycle after the causing input; no backpressure.
module round_control
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC    = DEF_FPS,
  parameter int COUNTDOWN_SECONDS = DEF_COUNTDOWN_S,
  parameter int ROUND_SECONDS     = DEF_ROUND_S,
  parameter int SCORE_W           = 10
) (
  input  logic            clk,
  input  logic            rst,
  round_control_if.slave  rc_if
);

  localparam int CD_W = $clog2(COUNTDOWN_SECONDS + 1);
  localparam int TL_W = $clog2(ROUND_SECONDS + 1);

  localparam logic [2:0] ST_START     = START;
  localparam logic [2:0] ST_COUNTDOWN = COUNTDOWN;
  localparam logic [2:0] ST_GAME      = GAME;
  localparam logic [2:0] ST_PAUSE     = PAUSE;
  localparam logic [2:0] ST_OVER      = OVER;

  localparam logic [CD_W-1:0]    CD_INIT   = CD_W'(COUNTDOWN_SECONDS);
  localparam logic [TL_W-1:0]    TL_INIT   = TL_W'(ROUND_SECONDS);
  localparam logic [CD_W-1:0]    CD_ONE    = CD_W'(1);
  localparam logic [TL_W-1:0]    TL_ONE    = TL_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [2:0]         mode_q, mode_d;
  logic               btn_prev_q;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [TL_W-1:0]    tl_q, tl_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               spawn_q, spawn_d;
  logic               done_q, done_d;

  logic btn_edge;
  logic sec_pulse;
  logic timer_en;
  logic timer_clr;
  logic final_sec;

  assign btn_edge  = rc_if.mouse_right & ~btn_prev_q;
  assign timer_en  = (mode_q == ST_COUNTDOWN) || (mode_q == ST_GAME);
  // Resume from PAUSE deliberately keeps the frame phase, so only these two entries clear.
  assign timer_clr = ((mode_q != ST_COUNTDOWN) && (mode_d == ST_COUNTDOWN)) ||
                     ((mode_q == ST_COUNTDOWN) && (mode_d == ST_GAME));
  assign final_sec = sec_pulse && (tl_q == TL_ONE);

  frame_sec_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_frame_sec_timer (
    .clk         (clk),
    .rst         (rst),
    .frame_tick_i(rc_if.frame_tick),
    .en_i        (timer_en),
    .clr_i       (timer_clr),
    .sec_pulse_o (sec_pulse)
  );

  always_comb begin
    mode_d  = mode_q;
    cd_d    = cd_q;
    tl_d    = tl_q;
    score_d = score_q;
    spawn_d = 1'b0;
    done_d  = 1'b0;
    case (mode_q)
      ST_START: begin
        if (btn_edge) begin
          mode_d  = ST_COUNTDOWN;
          cd_d    = CD_INIT;
          score_d = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (sec_pulse) begin
          if (cd_q == CD_ONE) begin
            mode_d  = ST_GAME;
            cd_d    = '0;
            tl_d    = TL_INIT;
            spawn_d = 1'b1;
          end else begin
            cd_d = cd_q - 1'b1;
          end
        end
      end
      ST_GAME: begin
        if (rc_if.hit && (score_q != SCORE_MAX)) begin
          score_d = score_q + 1'b1;
        end
        // End of round outranks both a pause request and the hit's respawn.
        if (final_sec) begin
          mode_d = ST_OVER;
          tl_d   = '0;
          done_d = 1'b1;
        end else begin
          if (sec_pulse) begin
            tl_d = tl_q - 1'b1;
          end
          if (btn_edge) begin
            mode_d = ST_PAUSE;
          end else if (rc_if.hit) begin
            spawn_d = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (btn_edge) begin
          mode_d = ST_GAME;
        end
      end
      ST_OVER: begin
        if (btn_edge) begin
          mode_d = ST_START;
        end
      end
      default: begin
        mode_d = ST_START;
      end
    endcase
  end

  // btn_prev resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= ST_START;
      btn_prev_q <= 1'b1;
      cd_q       <= '0;
      tl_q       <= '0;
      score_q    <= '0;
      spawn_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      btn_prev_q <= rc_if.mouse_right;
      cd_q       <= cd_d;
      tl_q       <= tl_d;
      score_q    <= score_d;
      spawn_q    <= spawn_d;
      done_q     <= done_d;
    end
  end

  assign rc_if.mode       = game_mode'(mode_q);
  assign rc_if.countdown  = cd_q;
  assign rc_if.time_left  = tl_q;
  assign rc_if.score      = score_q;
  assign rc_if.spawn_req  = spawn_q;
  assign rc_if.round_done = done_q;

endmodule

// File: tb/tb_round_control.sv
// Vector table with milestone expectations plus a per-cycle scoreboard against a behavioural model.
module tb_round_control;
  import game_pkg::*;

  localparam int FPS  = 4;
  localparam int CDS  = 3;
  localparam int RS   = 5;
  localparam int SW   = 3;
  localparam int SMAX = (1 << SW) - 1;
  localparam int CD_W = $clog2(CDS + 1);
  localparam int TL_W = $clog2(RS + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_control_if #(.CD_W(CD_W), .TL_W(TL_W), .SCORE_W(SW)) bus();

  round_control #(
    .FRAMES_PER_SEC   (FPS),
    .COUNTDOWN_SECONDS(CDS),
    .ROUND_SECONDS    (RS),
    .SCORE_W          (SW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rc_if(bus)
  );

  typedef struct {
    int mode; int cd; int tl; int score; int spawn; int done;
  } exp_t;

  typedef struct {
    int ft; int b; int h; int reps;
    game_mode mode; int cd; int tl; int score; int spawn; int done;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  game_mode m_mode;
  int m_cd, m_tl, m_score, m_fc, m_prev, m_spawn, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, "_mode"},  32'(bus.mode),       32'(e.mode));
    check({tag, "_cd"},    32'(bus.countdown),  32'(e.cd));
    check({tag, "_tl"},    32'(bus.time_left),  32'(e.tl));
    check({tag, "_score"}, 32'(bus.score),      32'(e.score));
    check({tag, "_spawn"}, 32'(bus.spawn_req),  32'(e.spawn));
    check({tag, "_done"},  32'(bus.round_done), 32'(e.done));
  endtask

  function automatic void model_reset();
    m_mode = START; m_cd = 0; m_tl = 0; m_score = 0;
    m_fc = 0; m_prev = 1; m_spawn = 0; m_done = 0;
  endfunction

  function automatic void model_step(input int ft, input int b, input int h);
    bit press, run, sec;
    press = (b != 0) && (m_prev == 0);
    run   = (m_mode == COUNTDOWN) || (m_mode == GAME);
    sec   = (ft != 0) && run && (m_fc == FPS - 1);
    m_spawn = 0;
    m_done  = 0;
    if (run && ft != 0) m_fc = (m_fc + 1) % FPS;
    case (m_mode)
      START: if (press) begin
        m_mode = COUNTDOWN; m_cd = CDS; m_score = 0; m_fc = 0;
      end
      COUNTDOWN: if (sec) begin
        m_cd = m_cd - 1;
        if (m_cd == 0) begin
          m_mode = GAME; m_tl = RS; m_spawn = 1; m_fc = 0;
        end
      end
      GAME: begin
        if (h != 0 && m_score < SMAX) m_score = m_score + 1;
        if (sec) m_tl = m_tl - 1;
        if (sec && m_tl == 0) begin
          m_mode = OVER; m_done = 1;
        end else if (press) begin
          m_mode = PAUSE;
        end else if (h != 0) begin
          m_spawn = 1;
        end
      end
      PAUSE: if (press) m_mode = GAME;
      OVER:  if (press) m_mode = START;
      default: m_mode = START;
    endcase
    m_prev = b;
  endfunction

  task automatic drive(input int ft, input int b, input int h);
    exp_t e;
    bus.frame_tick  = (ft != 0);
    bus.mouse_right = (b != 0);
    bus.hit         = (h != 0);
    model_step(ft, b, h);
    e.mode = int'(m_mode); e.cd = m_cd; e.tl = m_tl; e.score = m_score;
    e.spawn = m_spawn; e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check_outputs("sb", e);
    end
  endtask

  function automatic vec_t v(input int ft, input int b, input int h, input int reps,
                             input game_mode md, input int cd, input int tl,
                             input int sc, input int sp, input int dn);
    vec_t r;
    r.ft = ft; r.b = b; r.h = h; r.reps = reps; r.mode = md;
    r.cd = cd; r.tl = tl; r.score = sc; r.spawn = sp; r.done = dn;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t rexp;
    // ft b h reps | mode cd tl score spawn done (after the last repetition)
    tbl.push_back(v(0,1,0, 3, START,     0,0,0, 0,0));
    tbl.push_back(v(0,0,0, 1, START,     0,0,0, 0,0));
    tbl.push_back(v(0,1,0, 1, COUNTDOWN, 3,0,0, 0,0));
    tbl.push_back(v(0,0,0, 1, COUNTDOWN, 3,0,0, 0,0));
    tbl.push_back(v(1,1,0, 4, COUNTDOWN, 2,0,0, 0,0));
    tbl.push_back(v(1,0,0, 4, COUNTDOWN, 1,0,0, 0,0));
    tbl.push_back(v(1,0,0, 3, COUNTDOWN, 1,0,0, 0,0));
    tbl.push_back(v(1,0,0, 1, GAME,      0,5,0, 1,0));
    tbl.push_back(v(0,0,0, 1, GAME,      0,5,0, 0,0));
    tbl.push_back(v(0,0,1, 9, GAME,      0,5,7, 1,0));
    tbl.push_back(v(0,0,0, 1, GAME,      0,5,7, 0,0));
    tbl.push_back(v(1,0,0, 6, GAME,      0,4,7, 0,0));
    tbl.push_back(v(0,1,0, 1, PAUSE,     0,4,7, 0,0));
    tbl.push_back(v(1,0,0,10, PAUSE,     0,4,7, 0,0));
    tbl.push_back(v(0,0,1, 3, PAUSE,     0,4,7, 0,0));
    tbl.push_back(v(0,1,0, 1, GAME,      0,4,7, 0,0));
    tbl.push_back(v(1,0,0, 1, GAME,      0,4,7, 0,0));
    tbl.push_back(v(1,0,0, 1, GAME,      0,3,7, 0,0));
    tbl.push_back(v(1,0,0,11, GAME,      0,1,7, 0,0));
    tbl.push_back(v(1,0,1, 1, OVER,      0,0,7, 0,1));
    tbl.push_back(v(0,0,0, 1, OVER,      0,0,7, 0,0));
    tbl.push_back(v(0,1,0, 1, START,     0,0,7, 0,0));
    tbl.push_back(v(0,0,0, 1, START,     0,0,7, 0,0));
    tbl.push_back(v(0,1,0, 1, COUNTDOWN, 3,0,0, 0,0));
    tbl.push_back(v(1,0,0,12, GAME,      0,5,0, 1,0));
    tbl.push_back(v(1,0,0,19, GAME,      0,1,0, 0,0));
    tbl.push_back(v(1,1,1, 1, OVER,      0,0,1, 0,1));
    tbl.push_back(v(0,0,0, 1, OVER,      0,0,1, 0,0));
    tbl.push_back(v(0,1,0, 1, START,     0,0,1, 0,0));
    tbl.push_back(v(0,0,0, 1, START,     0,0,1, 0,0));
    tbl.push_back(v(0,1,0, 1, COUNTDOWN, 3,0,0, 0,0));
    tbl.push_back(v(0,0,0, 1, COUNTDOWN, 3,0,0, 0,0));
    tbl.push_back(v(1,0,0,12, GAME,      0,5,0, 1,0));
    tbl.push_back(v(0,0,1, 2, GAME,      0,5,2, 1,0));
    tbl.push_back(v(0,1,1, 1, PAUSE,     0,5,3, 0,0));
    tbl.push_back(v(0,0,0, 1, PAUSE,     0,5,3, 0,0));
    tbl.push_back(v(0,1,0, 1, GAME,      0,5,3, 0,0));
    tbl.push_back(v(0,0,0, 1, GAME,      0,5,3, 0,0));

    rexp.mode = int'(START); rexp.cd = 0; rexp.tl = 0; rexp.score = 0;
    rexp.spawn = 0; rexp.done = 0;

    // Button held high throughout reset.
    bus.frame_tick = 1'b0; bus.mouse_right = 1'b1; bus.hit = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", rexp);
    rst = 1'b1;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) drive(tbl[i].ft, tbl[i].b, tbl[i].h);
      rexp.mode = int'(tbl[i].mode); rexp.cd = tbl[i].cd; rexp.tl = tbl[i].tl;
      rexp.score = tbl[i].score; rexp.spawn = tbl[i].spawn; rexp.done = tbl[i].done;
      check_outputs($sformatf("vec%0d", i), rexp);
    end

    // Asynchronous reset mid-GAME, between clock edges.
    #2;
    rst = 1'b0;
    #1;
    rexp.mode = int'(START); rexp.cd = 0; rexp.tl = 0; rexp.score = 0;
    rexp.spawn = 0; rexp.done = 0;
    check_outputs("async_rst", rexp);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 0);
    drive(0, 1, 0);
    drive(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_control.md
# round_control

Game-round sequencer for the VGA mouse game. It sits between the mouse front-end and the drawing and target logic, and drives the game mode shown on screen. Its sequence is start screen, a countdown, a timed play phase with pause, then game over. It keeps the score and second counters and tells the target generator when to spawn a new target.

## Interface
- FRAMES_PER_SEC, 60: frame_tick pulses per second; minimum 2.
- COUNTDOWN_SECONDS, 3: countdown length; minimum 1.
- ROUND_SECONDS, 30: play-phase length; minimum 1.
- SCORE_W, 10: score width.
- Derived localparams: CD_W = $clog2(COUNTDOWN_SECONDS+1), TL_W = $clog2(ROUND_SECONDS+1).
- Ports:
  - clk  in  1  system clock; the only clock.
  - rst  in  1  asynchronous, active-low reset.
  - frame_tick  in  1  one-cycle pulse per VGA frame, synchronous to clk.
  - mouse_right  in  1  right-button level, synchronous to clk.
  - hit  in  1  one-cycle pulse, target hit by cursor.
  - mode  out  game_mode  current phase.
  - countdown  out  CD_W  seconds left in COUNTDOWN.
  - time_left  out  TL_W  seconds left in GAME/PAUSE.
  - score  out  SCORE_W  hits this round, saturating.
  - spawn_req  out  1  one-cycle request for a new target.
  - round_done  out  1  one-cycle pulse on entering OVER.

## Operation
- Button edge: rising edge of mouse_right = mouse_right & ~btn_prev.
  - btn_prev resets to 1, so a button held through reset is not an edge.
- Second prescaler: frame_cnt counts frame_tick modulo FRAMES_PER_SEC.
  - sec_pulse is asserted when frame_tick arrives with frame_cnt == FRAMES_PER_SEC-1.
  - Advances only in COUNTDOWN and GAME; frozen in PAUSE; cleared on entry to COUNTDOWN and GAME.
- FSM states (game_mode): START, COUNTDOWN, GAME, PAUSE, OVER.
- START:
  - Button edge goes to COUNTDOWN: countdown = COUNTDOWN_SECONDS, score = 0.
- COUNTDOWN:
  - sec_pulse decrements countdown.
  - sec_pulse with countdown == 1 goes to GAME: countdown = 0, time_left = ROUND_SECONDS, spawn_req pulses.
  - Button edges are ignored.
- GAME:
  - hit increments score, saturating at all-ones, and pulses spawn_req the next cycle.
  - sec_pulse decrements time_left.
  - sec_pulse with time_left == 1 goes to OVER: time_left = 0, round_done pulses.
  - Button edge goes to PAUSE.
- PAUSE:
  - hit is ignored; counters are frozen.
  - Button edge returns to GAME with the frame_cnt phase preserved, so no clear on this entry.
- OVER:
  - score is held.
  - Button edge goes to START; score is held until the next COUNTDOWN entry.
- Simultaneous events:
  - hit together with final sec_pulse: the hit is counted, then OVER, and no spawn_req.
  - Button edge together with final sec_pulse in GAME: OVER wins and the edge is dropped.
  - Button edge together with hit in GAME: the hit is counted, then PAUSE, and no spawn_req.
- Illegal or unreachable encodings return to START.

## Timing
- All outputs are registered.
- Reset values: mode START, countdown 0, time_left 0, score 0, spawn_req 0, round_done 0, frame_cnt 0.
- Reset is asynchronous assert, synchronous deassert handled upstream. Reset mid-round returns to START immediately.
- mode changes one cycle after the qualifying edge or sec_pulse cycle.
- The spawn_req at round start coincides with the first cycle of mode == GAME.
- round_done coincides with the first cycle of mode == OVER.
- score and countdown/time_left update one cycle after hit or sec_pulse.

## Structure
- game_pkg:
  - Extend game_mode enum with COUNTDOWN, PAUSE, OVER. START and GAME keep their existing encodings so existing consumers are unaffected.
  - Add default timing constants (DEF_FPS = 60, DEF_COUNTDOWN_S = 3, DEF_ROUND_S = 30).
- One sub-module, frame_sec_timer: frame_tick to sec_pulse prescaler with enable and clear inputs.
- The FSM and counters stay in round_control.

## Test plan
Bench parameters: FRAMES_PER_SEC=4, COUNTDOWN_SECONDS=3, ROUND_SECONDS=5, SCORE_W=3.
- Reset with mouse_right held high, then release reset -> mode stays START. Release and press again -> COUNTDOWN, countdown=3.
- 12 frame_ticks in COUNTDOWN -> countdown steps 3,2,1, then mode=GAME, time_left=5, spawn_req high for exactly one cycle on the first GAME cycle.
- 9 hit pulses in GAME -> score reaches 7 and stays 7; spawn_req follows each hit by one cycle.
- Button press after 6 ticks of GAME -> PAUSE. 10 ticks plus 3 hits -> time_left and score unchanged. Press -> GAME; 2 more ticks produce the next decrement (phase kept).
- hit and button edge on the same cycle as the final sec_pulse -> mode=OVER, time_left=0, score incremented, round_done one cycle, no spawn_req, no PAUSE.
- Reset asserted mid-GAME asynchronously between clock edges -> all outputs reset values before the next clk edge.
